instr_fetch_sequencer: RTL

Controller that sequences instruction fetch from the byte-wide program memory and feeds the instruction decoder. It walks a program counter, issues memory reads, assembles 1- or 2-byte instructions into 16-bit words, buffers them in a small queue, and delivers them to the decoder over a start/ready handshake. A redirect input flushes all fetch state and restarts at a new address.

---
 rtl/instr_fetch_sequencer_if.sv | 27 ++
 rtl/instr_fetch_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer_if.sv
// Fetch-sequencer bus: byte-wide program-memory read port plus the
// decoder-side start/ready handshake and queue occupancy.
interface instr_fetch_sequencer_if #(
  parameter int BYTE   = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2
);
  logic                   mem_rd;
  logic [ADDR_W-1:0]      mem_addr;
  logic [BYTE-1:0]        mem_data;
  logic                   dec_start;
  logic [2*BYTE-1:0]      dec_word;
  logic                   dec_ready;
  logic [$clog2(DEPTH):0] q_count;

  // Sequencer side
  modport master (
    output mem_rd, mem_addr, dec_start, dec_word, q_count,
    input  mem_data, dec_ready
  );

  // Memory / decoder side
  modport slave (
    input  mem_rd, mem_addr, dec_start, dec_word, q_count,
    output mem_data, dec_ready
  );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through byte-wide program memory,
// assembles 1- or 2-byte instructions into {opcode, operand} words and queues
// them for the decoder. Redirect flushes everything and restarts at a new PC.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ISSUE_OP    | read opcode byte at pc when run=1, otherwise idle
// CAPTURE_OP  | latch opcode; bit7 set -> operand follows, else operand=0
// ISSUE_ARG   | read operand byte at pc (run ignored, instruction finishes)
// CAPTURE_ARG | latch operand byte
// PUSH        | write word into queue; stalls here while queue is full
module instr_fetch_sequencer #(
  parameter int BYTE   = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  redirect,
  input  logic [ADDR_W-1:0]     redirect_addr,
  instr_fetch_sequencer_if.master bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    ISSUE_OP,
    CAPTURE_OP,
    ISSUE_ARG,
    CAPTURE_ARG,
    PUSH
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [BYTE-1:0]   opcode;
  logic [BYTE-1:0]   operand;

  logic [2*BYTE-1:0] q_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              pop;
  logic              push;

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pop  = (count != '0) && bus.dec_ready;
  assign push = (state == PUSH) && ((count != FULL) || pop);

  // Read strobe is held low while reset is asserted so no read escapes the
  // cycle in which the synchronous reset is still being applied.
  assign bus.mem_rd    = reset && (((state == ISSUE_OP) && run) || (state == ISSUE_ARG));
  assign bus.mem_addr  = pc;
  assign bus.dec_start = (count != '0);
  assign bus.dec_word  = q_mem[head];
  assign bus.q_count   = count;

  // Fetch FSM: program counter walk and opcode/operand assembly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ISSUE_OP;
      pc      <= '0;
      opcode  <= '0;
      operand <= '0;
    end else if (redirect) begin
      state <= ISSUE_OP;
      pc    <= redirect_addr;
    end else begin
      unique case (state)
        ISSUE_OP: begin
          if (run) begin
            pc    <= pc + ADDR_W'(1);
            state <= CAPTURE_OP;
          end
        end
        CAPTURE_OP: begin
          opcode <= bus.mem_data;
          if (bus.mem_data[BYTE-1]) begin
            state <= ISSUE_ARG;
          end else begin
            operand <= '0;
            state   <= PUSH;
          end
        end
        ISSUE_ARG: begin
          pc    <= pc + ADDR_W'(1);
          state <= CAPTURE_ARG;
        end
        CAPTURE_ARG: begin
          operand <= bus.mem_data;
          state   <= PUSH;
        end
        PUSH: begin
          if (push) state <= ISSUE_OP;
        end
        default: state <= ISSUE_OP;
      endcase
    end
  end

  // Circular instruction queue; redirect empties it but leaves stale entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q_mem[i] <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_mem[tail] <= {opcode, operand};
        tail        <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule
